grid_wr_arbiter: RTL and testbench

Sequential arbiter that shares the single game-grid write port (16×16 cells, 5-bit cell value) between two requesters: port 1 (mouse/player input path) and port 2 (FPGA game logic). It uses a request/acknowledge handshake, grants the two ports round-robin and registers the winning write onto the grid RAM write port. An optional sweep engine clears the whole grid. It sits between the two write sources and the grid memory, replacing the free-running selector with a fair, collision-free scheduler.

---
 rtl/grid_wr_arbiter_pkg.sv | 16 +
 rtl/grid_wr_arbiter_clear_sweeper.sv | 77 +++++++
 rtl/grid_wr_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_grid_wr_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_wr_arbiter_pkg.sv
// Shared grid definitions for the grid write path: widths, clear value, last-cell
// index and the arbiter state encoding. Also imported by the grid RAM and mouse-path blocks.
package grid_wr_arbiter_pkg;

  localparam int unsigned         GRID_X_W         = 4;
  localparam int unsigned         GRID_Y_W         = 4;
  localparam int unsigned         GRID_V_W         = 5;
  localparam logic [GRID_V_W-1:0] GRID_CLEAR_VALUE = 5'd0;
  localparam logic [3:0]          GRID_LAST_CELL   = 4'd15;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_e;

endpackage

// File: rtl/grid_wr_arbiter_clear_sweeper.sv
// Nested x/y sweep counter for the full-grid clear. x is the inner index.
// While busy, the counter holds the cell currently on the grid bus; x_o/y_o give the next cell.
module grid_clear_sweeper
  import grid_wr_arbiter_pkg::*;
#(
  parameter int unsigned X_W = GRID_X_W,
  parameter int unsigned Y_W = GRID_Y_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  output logic           busy_o,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           last_o,
  output logic           next_last_o
);

  localparam logic [X_W-1:0] LAST_X = X_W'(GRID_LAST_CELL);
  localparam logic [Y_W-1:0] LAST_Y = Y_W'(GRID_LAST_CELL);
  localparam logic [X_W-1:0] ONE_X  = X_W'(1);
  localparam logic [Y_W-1:0] ONE_Y  = Y_W'(1);

  logic           busy_q, busy_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [X_W-1:0] x_inc_s;
  logic [Y_W-1:0] y_inc_s;
  logic           at_last_s;

  assign x_inc_s   = (x_q == LAST_X) ? '0 : x_q + ONE_X;
  assign y_inc_s   = (x_q == LAST_X) ? y_q + ONE_Y : y_q;
  assign at_last_s = (x_q == LAST_X) && (y_q == LAST_Y);

  // Next sweep position: step while busy, stop after the last cell, arm on start.
  always_comb begin
    busy_d = busy_q;
    x_d    = x_q;
    y_d    = y_q;
    if (busy_q) begin
      if (at_last_s) begin
        busy_d = 1'b0;
        x_d    = '0;
        y_d    = '0;
      end else begin
        x_d = x_inc_s;
        y_d = y_inc_s;
      end
    end else if (start_i) begin
      busy_d = 1'b1;
      x_d    = '0;
      y_d    = '0;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Sweep state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      busy_q <= busy_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  assign busy_o      = busy_q;
  assign x_o         = busy_q ? x_inc_s : '0;
  assign y_o         = busy_q ? y_inc_s : '0;
  assign last_o      = busy_q && at_last_s;
  assign next_last_o = (x_o == LAST_X) && (y_o == LAST_Y);

endmodule

// File: rtl/grid_wr_arbiter.sv
// Round-robin arbiter for the grid write port between the mouse path (port 1) and game logic
// (port 2). The full-grid clear sweep is compiled in only when GRID_ARB_CLEAR_EN is defined.
module grid_wr_arbiter
  import grid_wr_arbiter_pkg::*;
#(
  parameter int unsigned     X_W         = GRID_X_W,
  parameter int unsigned     Y_W         = GRID_Y_W,
  parameter int unsigned     V_W         = GRID_V_W,
  parameter logic [V_W-1:0]  CLEAR_VALUE = GRID_CLEAR_VALUE
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_1,
  input  logic [X_W-1:0] cell_x_1,
  input  logic [Y_W-1:0] cell_y_1,
  input  logic [V_W-1:0] new_value_1,
  input  logic           req_2,
  input  logic [X_W-1:0] cell_x_2,
  input  logic [Y_W-1:0] cell_y_2,
  input  logic [V_W-1:0] new_value_2,
  output logic           ack_1,
  output logic           ack_2,
  output logic [X_W-1:0] cell_x_out,
  output logic [Y_W-1:0] cell_y_out,
  output logic           we_out,
  output logic [V_W-1:0] new_value_out,
  output logic           grant_sel,
  input  logic           clear_start,
  output logic           clear_busy,
  output logic           clear_done
);

  arb_state_e     state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [V_W-1:0] v_q, v_d;
  logic           we_q, we_d;
  logic           ack_1_q, ack_1_d;
  logic           ack_2_q, ack_2_d;
  logic           grant_q, grant_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           elig_1_s, elig_2_s, win_2_s;
  logic           clear_req_s;
  logic           sw_start_s, sw_busy_s, sw_last_s, sw_next_last_s;
  logic [X_W-1:0] sw_x_s;
  logic [Y_W-1:0] sw_y_s;

`ifdef GRID_ARB_CLEAR_EN
  assign clear_req_s = clear_start;

  grid_clear_sweeper #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_sweeper (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (sw_start_s),
    .busy_o      (sw_busy_s),
    .x_o         (sw_x_s),
    .y_o         (sw_y_s),
    .last_o      (sw_last_s),
    .next_last_o (sw_next_last_s)
  );

  logic unused_sweep_s;
  assign unused_sweep_s = sw_busy_s;
`else
  assign clear_req_s    = 1'b0;
  assign sw_busy_s      = 1'b0;
  assign sw_last_s      = 1'b0;
  assign sw_next_last_s = 1'b0;
  assign sw_x_s         = '0;
  assign sw_y_s         = '0;

  logic unused_clear_s;
  assign unused_clear_s = ^{clear_start, sw_start_s, sw_busy_s, CLEAR_VALUE};
`endif

  // A port being acked this cycle is masked so it cannot win twice in a row.
  assign elig_1_s = req_1 && !ack_1_q;
  assign elig_2_s = req_2 && !ack_2_q;
  assign win_2_s  = elig_2_s && (!elig_1_s || !last_grant_q);

  // Next state and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    x_d          = x_q;
    y_d          = y_q;
    v_d          = v_q;
    we_d         = 1'b0;
    ack_1_d      = 1'b0;
    ack_2_d      = 1'b0;
    grant_d      = grant_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    sw_start_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_req_s) begin
          state_d    = ST_CLEAR;
          sw_start_s = 1'b1;
          we_d       = 1'b1;
          x_d        = sw_x_s;
          y_d        = sw_y_s;
          v_d        = CLEAR_VALUE;
          busy_d     = 1'b1;
        end else if (elig_1_s || elig_2_s) begin
          we_d         = 1'b1;
          grant_d      = win_2_s;
          last_grant_d = win_2_s;
          if (win_2_s) begin
            x_d     = cell_x_2;
            y_d     = cell_y_2;
            v_d     = new_value_2;
            ack_2_d = 1'b1;
          end else begin
            x_d     = cell_x_1;
            y_d     = cell_y_1;
            v_d     = new_value_1;
            ack_1_d = 1'b1;
          end
        end else begin
          we_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        // The last cell is already on the bus; leave without another write.
        if (sw_last_s) begin
          state_d = ST_IDLE;
        end else begin
          we_d   = 1'b1;
          x_d    = sw_x_s;
          y_d    = sw_y_s;
          v_d    = CLEAR_VALUE;
          busy_d = 1'b1;
          done_d = sw_next_last_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; last_grant resets to port 2 so port 1 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      x_q          <= '0;
      y_q          <= '0;
      v_q          <= '0;
      we_q         <= 1'b0;
      ack_1_q      <= 1'b0;
      ack_2_q      <= 1'b0;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      x_q          <= x_d;
      y_q          <= y_d;
      v_q          <= v_d;
      we_q         <= we_d;
      ack_1_q      <= ack_1_d;
      ack_2_q      <= ack_2_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign cell_x_out    = x_q;
  assign cell_y_out    = y_q;
  assign new_value_out = v_q;
  assign we_out        = we_q;
  assign ack_1         = ack_1_q;
  assign ack_2         = ack_2_q;
  assign grant_sel     = grant_q;
  assign clear_busy    = busy_q;
  assign clear_done    = done_q;

endmodule

// File: tb/tb_grid_wr_arbiter.sv
// Scoreboard bench for grid_wr_arbiter; clear-sweep scenarios run when GRID_ARB_CLEAR_EN is defined.
module tb_grid_wr_arbiter;

  typedef struct packed {
    logic       p;
    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] v;
  } wr_t;

  logic       clk;
  logic       rst_n;
  logic       req_1, req_2;
  logic [3:0] cell_x_1, cell_x_2, cell_y_1, cell_y_2;
  logic [4:0] new_value_1, new_value_2;
  logic       ack_1, ack_2, we_out, grant_sel;
  logic [3:0] cell_x_out, cell_y_out;
  logic [4:0] new_value_out;
  logic       clear_start, clear_busy, clear_done;

  int  checks   = 0;
  int  failures = 0;
  logic bench_last;
  wr_t exp_q[$];

  grid_wr_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_1         (req_1),
    .cell_x_1      (cell_x_1),
    .cell_y_1      (cell_y_1),
    .new_value_1   (new_value_1),
    .req_2         (req_2),
    .cell_x_2      (cell_x_2),
    .cell_y_2      (cell_y_2),
    .new_value_2   (new_value_2),
    .ack_1         (ack_1),
    .ack_2         (ack_2),
    .cell_x_out    (cell_x_out),
    .cell_y_out    (cell_y_out),
    .we_out        (we_out),
    .new_value_out (new_value_out),
    .grant_sel     (grant_sel),
    .clear_start   (clear_start),
    .clear_busy    (clear_busy),
    .clear_done    (clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_1 = 1'b0; req_2 = 1'b0; clear_start = 1'b0;
    cell_x_1 = 4'd0; cell_y_1 = 4'd0; new_value_1 = 5'd0;
    cell_x_2 = 4'd0; cell_y_2 = 4'd0; new_value_2 = 5'd0;
    repeat (2) tick();
    rst_n = 1'b1;
    bench_last = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    do_reset();
    obs = {cell_x_out, cell_y_out, new_value_out, we_out, ack_1, ack_2, grant_sel, clear_busy, clear_done};
    checks++;
    if (obs !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=%h", obs, 23'd0);
    end
    tick();
    obs = {cell_x_out, cell_y_out, new_value_out, we_out, ack_1, ack_2, grant_sel, clear_busy, clear_done};
    checks++;
    if (obs !== 23'd0) begin
      failures++;
      $display("FAIL idle_after_reset got=%h want=%h", obs, 23'd0);
    end
  endtask

  task automatic test_tie();
    wr_t e;
    logic [16:0] obs, expv;
    req_1 = 1'b1; cell_x_1 = 4'd1; cell_y_1 = 4'd1; new_value_1 = 5'd1;
    req_2 = 1'b1; cell_x_2 = 4'd2; cell_y_2 = 4'd2; new_value_2 = 5'd2;
    exp_q.push_back('{p: 1'b0, x: 4'd1, y: 4'd1, v: 5'd1});
    exp_q.push_back('{p: 1'b1, x: 4'd2, y: 4'd2, v: 5'd2});
    bench_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (i == 0) req_1 = 1'b0;
      else        req_2 = 1'b0;
      e = exp_q.pop_front();
      bench_last = e.p;
      obs  = {we_out, ack_1, ack_2, grant_sel, cell_x_out, cell_y_out, new_value_out};
      expv = {1'b1, ~e.p, e.p, e.p, e.x, e.y, e.v};
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL tie_grant%0d got=%h want=%h", i, obs, expv);
      end
    end
    tick();
    checks++;
    if ({we_out, ack_1, ack_2} !== 3'b000) begin
      failures++;
      $display("FAIL tie_quiet got=%b want=000", {we_out, ack_1, ack_2});
    end
  endtask

  task automatic test_single();
    wr_t e;
    logic [16:0] obs, expv;
    req_1 = 1'b1; cell_x_1 = 4'd3; cell_y_1 = 4'd7; new_value_1 = 5'd9;
    exp_q.push_back('{p: 1'b0, x: 4'd3, y: 4'd7, v: 5'd9});
    tick();
    req_1 = 1'b0;
    e = exp_q.pop_front();
    bench_last = e.p;
    obs  = {we_out, ack_1, ack_2, grant_sel, cell_x_out, cell_y_out, new_value_out};
    expv = {1'b1, ~e.p, e.p, e.p, e.x, e.y, e.v};
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL single_write got=%h want=%h", obs, expv);
    end
    tick();
    obs  = {we_out, ack_1, ack_2, grant_sel, cell_x_out, cell_y_out, new_value_out};
    expv = {3'b000, 1'b0, 4'd3, 4'd7, 5'd9};
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL single_hold got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_continuous();
    wr_t e;
    logic [16:0] obs, expv;
    logic a1, a2, w, prev_a1, prev_a2;
    a1 = 1'b0; a2 = 1'b0; prev_a1 = 1'b0; prev_a2 = 1'b0;
    req_1 = 1'b1; cell_x_1 = 4'd4; cell_y_1 = 4'd5; new_value_1 = 5'd6;
    req_2 = 1'b1; cell_x_2 = 4'd10; cell_y_2 = 4'd11; new_value_2 = 5'd20;
    for (int i = 0; i < 10; i++) begin
      if (!a1 && !a2) w = ~bench_last;
      else            w = !a2;
      if (w) exp_q.push_back('{p: 1'b1, x: cell_x_2, y: cell_y_2, v: new_value_2});
      else   exp_q.push_back('{p: 1'b0, x: cell_x_1, y: cell_y_1, v: new_value_1});
      tick();
      e = exp_q.pop_front();
      obs  = {we_out, ack_1, ack_2, grant_sel, cell_x_out, cell_y_out, new_value_out};
      expv = {1'b1, ~e.p, e.p, e.p, e.x, e.y, e.v};
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL cont_grant%0d got=%h want=%h", i, obs, expv);
      end
      checks++;
      if ((ack_1 && prev_a1) || (ack_2 && prev_a2)) begin
        failures++;
        $display("FAIL cont_repeat%0d got=%b%b want=no repeat", i, ack_1, ack_2);
      end
      prev_a1 = ack_1; prev_a2 = ack_2;
      a1 = ~w; a2 = w; bench_last = w;
      if (w) begin
        cell_x_2 = cell_x_2 + 4'd1; new_value_2 = new_value_2 + 5'd3;
      end else begin
        cell_y_1 = cell_y_1 + 4'd2; new_value_1 = new_value_1 + 5'd1;
      end
    end
    req_1 = 1'b0; req_2 = 1'b0;
    tick();
    tick();
    checks++;
    if ({we_out, ack_1, ack_2} !== 3'b000) begin
      failures++;
      $display("FAIL cont_quiet got=%b want=000", {we_out, ack_1, ack_2});
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] obs, expv;
    logic a1;
    a1 = 1'b0;
    req_1 = 1'b1; cell_x_1 = 4'd8; cell_y_1 = 4'd1; new_value_1 = 5'd17;
    for (int i = 0; i < 6; i++) begin
      if (!a1) exp_q.push_back('{p: 1'b0, x: cell_x_1, y: cell_y_1, v: new_value_1});
      tick();
      if (!a1) begin
        wr_t e;
        e = exp_q.pop_front();
        bench_last = 1'b0;
        expv = {1'b1, 1'b1, 1'b0, 1'b0, e.x, e.y, e.v};
        cell_x_1 = cell_x_1 + 4'd1; new_value_1 = new_value_1 + 5'd2;
      end else begin
        expv = {3'b000, 1'b0, cell_x_out, cell_y_out, new_value_out};
        expv[16:13] = 4'b0000;
      end
      obs = {we_out, ack_1, ack_2, grant_sel, cell_x_out, cell_y_out, new_value_out};
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL b2b_cycle%0d got=%h want=%h", i, obs, expv);
      end
      a1 = ~a1;
    end
    req_1 = 1'b0;
    tick();
  endtask

`ifdef GRID_ARB_CLEAR_EN
  task automatic test_clear();
    wr_t e;
    logic [16:0] obs, expv;
    logic [11:0] cobs, cexp;
    int c;
    clear_start = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      tick();
      clear_start = (k == 50);
      c = k - 1;
      cobs = {we_out, ack_1, ack_2, clear_busy, clear_done, cell_x_out, cell_y_out, new_value_out} >> 5;
      cexp = {1'b1, 1'b0, 1'b0, 1'b1, (k == 256), c[3:0], c[7:4]} >> 1;
      checks++;
      if ({cobs, new_value_out, cell_y_out[0]} !== {cexp, 5'd0, c[4]} ||
          {cell_x_out, cell_y_out, clear_done} !== {c[3:0], c[7:4], (k == 256)}) begin
        failures++;
        $display("FAIL clear_cell%0d got=%b%b%b%b%b x=%0d y=%0d v=%0d want x=%0d y=%0d done=%0d",
                 k, we_out, ack_1, ack_2, clear_busy, clear_done, cell_x_out, cell_y_out,
                 new_value_out, c[3:0], c[7:4], (k == 256));
      end
      if (k == 10) begin
        req_2 = 1'b1; cell_x_2 = 4'd9; cell_y_2 = 4'd10; new_value_2 = 5'd11;
        exp_q.push_back('{p: 1'b1, x: 4'd9, y: 4'd10, v: 5'd11});
      end
    end
    tick();
    checks++;
    if ({we_out, ack_1, ack_2, clear_busy, clear_done} !== 5'b00000) begin
      failures++;
      $display("FAIL clear_exit got=%b want=00000", {we_out, ack_1, ack_2, clear_busy, clear_done});
    end
    tick();
    req_2 = 1'b0;
    e = exp_q.pop_front();
    bench_last = e.p;
    obs  = {we_out, ack_1, ack_2, grant_sel, cell_x_out, cell_y_out, new_value_out};
    expv = {1'b1, ~e.p, e.p, e.p, e.x, e.y, e.v};
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL clear_pending_req got=%h want=%h", obs, expv);
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    wr_t e;
    logic [22:0] zobs;
    logic [16:0] obs, expv;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (99) tick();
    rst_n = 1'b0;
    #1;
    zobs = {cell_x_out, cell_y_out, new_value_out, we_out, ack_1, ack_2, grant_sel, clear_busy, clear_done};
    checks++;
    if (zobs !== 23'd0) begin
      failures++;
      $display("FAIL midsweep_reset got=%h want=%h", zobs, 23'd0);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    bench_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({we_out, clear_busy, clear_done} !== 3'b000) begin
        failures++;
        $display("FAIL midsweep_noresume%0d got=%b want=000", i, {we_out, clear_busy, clear_done});
      end
    end
    req_1 = 1'b1; cell_x_1 = 4'd7; cell_y_1 = 4'd8; new_value_1 = 5'd9;
    exp_q.push_back('{p: 1'b0, x: 4'd7, y: 4'd8, v: 5'd9});
    tick();
    req_1 = 1'b0;
    e = exp_q.pop_front();
    bench_last = e.p;
    obs  = {we_out, ack_1, ack_2, grant_sel, cell_x_out, cell_y_out, new_value_out};
    expv = {1'b1, ~e.p, e.p, e.p, e.x, e.y, e.v};
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL midsweep_req got=%h want=%h", obs, expv);
    end
    tick();
  endtask
`else
  task automatic test_clear_disabled();
    wr_t e;
    logic [16:0] obs, expv;
    clear_start = 1'b1;
    req_1 = 1'b1; cell_x_1 = 4'd4; cell_y_1 = 4'd5; new_value_1 = 5'd6;
    exp_q.push_back('{p: 1'b0, x: 4'd4, y: 4'd5, v: 5'd6});
    tick();
    clear_start = 1'b0;
    req_1 = 1'b0;
    e = exp_q.pop_front();
    bench_last = e.p;
    obs  = {we_out, ack_1, ack_2, grant_sel, cell_x_out, cell_y_out, new_value_out};
    expv = {1'b1, ~e.p, e.p, e.p, e.x, e.y, e.v};
    checks++;
    if (obs !== expv || {clear_busy, clear_done} !== 2'b00) begin
      failures++;
      $display("FAIL noclear_req got=%h busy_done=%b want=%h busy_done=00", obs, {clear_busy, clear_done}, expv);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({we_out, ack_1, ack_2, clear_busy, clear_done} !== 5'b00000) begin
        failures++;
        $display("FAIL noclear_quiet%0d got=%b want=00000", i, {we_out, ack_1, ack_2, clear_busy, clear_done});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_continuous();
    test_back_to_back();
`ifdef GRID_ARB_CLEAR_EN
    test_clear();
    test_reset_mid_sweep();
`else
    test_clear_disabled();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
